// File: rtl/seven_segment_move_history.sv
// Move-history display: stores the most recent moves in a circular buffer and renders
// NUM_MOVES face/modifier digit pairs on active-low seven-segment outputs, with undo and scroll-back.
module seven_segment_move_history #(
  parameter int NUM_MOVES = 3,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 1,
  parameter int BLINK_W   = 24
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         move_valid,
  input  logic [2:0]                   move_face,
  input  logic [1:0]                   move_turn,
  output logic                         move_ready,
  input  logic                         undo,
  input  logic                         scroll_older,
  input  logic                         scroll_newer,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [14*NUM_MOVES-1:0]      hex_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NUM_C   = CNT_W'(NUM_MOVES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [4:0]          mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    view_off;
  logic [CNT_W-1:0]    max_off;
  logic [BLINK_W-1:0]  blink_cnt;
  logic [14*NUM_MOVES-1:0] hex_next;
  logic                push_ok;
  logic                undo_ok;
  logic                blink_on;

  function automatic logic [6:0] face_seg(input logic [2:0] f);
    case (f)
      3'd0:    face_seg = 7'b1000001;
      3'd1:    face_seg = 7'b0101111;
      3'd2:    face_seg = 7'b1000111;
      3'd3:    face_seg = 7'b0001110;
      3'd4:    face_seg = 7'b0000011;
      3'd5:    face_seg = 7'b0100001;
      default: face_seg = 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] turn_seg(input logic [1:0] t);
    case (t)
      2'd0:    turn_seg = 7'b1111111;
      2'd1:    turn_seg = 7'b1111101;
      2'd2:    turn_seg = 7'b0100100;
      default: turn_seg = 7'b0111111;
    endcase
  endfunction

  // Undo takes priority: holding ready low keeps a concurrent move pending.
  assign move_ready = !undo && ((OVERWRITE != 0) || (cnt_q < DEPTH_C));
  assign push_ok    = move_valid && move_ready;
  assign undo_ok    = undo && (cnt_q != '0);
  assign max_off    = (cnt_q > NUM_C) ? (cnt_q - NUM_C) : '0;
  assign count      = cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr    <= '0;
      cnt_q     <= '0;
      view_off  <= '0;
      blink_cnt <= '0;
      hex_out   <= '1;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
      hex_out   <= hex_next;
      if (undo_ok) begin
        wr_ptr   <= wr_ptr - PTR_W'(1);
        cnt_q    <= cnt_q - CNT_W'(1);
        view_off <= '0;
      end else if (push_ok) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        if (cnt_q != DEPTH_C) cnt_q <= cnt_q + CNT_W'(1);
        view_off <= '0;
      end else if (scroll_older && !scroll_newer && (view_off < max_off)) begin
        view_off <= view_off + CNT_W'(1);
      end else if (scroll_newer && !scroll_older && (view_off != '0)) begin
        view_off <= view_off - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLOCK_50) begin
    if (!reset && push_ok) mem[wr_ptr] <= {move_face, move_turn};
  end

  always_comb begin
    hex_next = '1;
    blink_on = (view_off != '0) && blink_cnt[BLINK_W-1];
    for (int k = 0; k < NUM_MOVES; k++) begin : g_slot
      logic [CNT_W:0]   slot_pos;
      logic [PTR_W-1:0] rd_idx;
      logic [4:0]       entry;
      slot_pos = {1'b0, view_off} + (CNT_W+1)'(k);
      rd_idx   = wr_ptr - PTR_W'(1) - view_off[PTR_W-1:0] - PTR_W'(k);
      entry    = mem[rd_idx];
      if (slot_pos < {1'b0, cnt_q}) begin
        hex_next[14*k +: 14] = {blink_on ? SEG_BLANK : face_seg(entry[4:2]),
                                turn_seg(entry[1:0])};
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_move_history.sv
// Bench for seven_segment_move_history: two instances (overwrite and stall) share stimulus
// and are compared every cycle against a list-based model of the move history.
module tb_seven_segment_move_history;
  localparam int NM = 3;
  localparam int DP = 16;
  localparam int BW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, move_valid = 1'b0, undo = 1'b0, so = 1'b0, sn = 1'b0;
  logic [2:0] face = 3'd0;
  logic [1:0] turn = 2'd0;
  logic ready_a, ready_b;
  logic [4:0] count_a, count_b;
  logic [14*NM-1:0] hex_a, hex_b;

  seven_segment_move_history #(.NUM_MOVES(NM), .DEPTH(DP), .OVERWRITE(1), .BLINK_W(BW)) dut_a (
    .CLOCK_50(clk), .reset(reset), .move_valid(move_valid), .move_face(face), .move_turn(turn),
    .move_ready(ready_a), .undo(undo), .scroll_older(so), .scroll_newer(sn),
    .count(count_a), .hex_out(hex_a));

  seven_segment_move_history #(.NUM_MOVES(NM), .DEPTH(DP), .OVERWRITE(0), .BLINK_W(BW)) dut_b (
    .CLOCK_50(clk), .reset(reset), .move_valid(move_valid), .move_face(face), .move_turn(turn),
    .move_ready(ready_b), .undo(undo), .scroll_older(so), .scroll_newer(sn),
    .count(count_b), .hex_out(hex_b));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: history as an oldest-first list ----------------
  logic [4:0] hist [2][DP];
  int cnt [2];
  int vo [2];
  int bcnt = 0;
  logic [14*NM-1:0] exp_hex [2];
  bit mvalid = 0;

  function automatic logic [6:0] face_seg(input logic [2:0] f);
    case (f)
      3'd0: return 7'b1000001;
      3'd1: return 7'b0101111;
      3'd2: return 7'b1000111;
      3'd3: return 7'b0001110;
      3'd4: return 7'b0000011;
      3'd5: return 7'b0100001;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] turn_seg(input logic [1:0] t);
    case (t)
      2'd0: return 7'b1111111;
      2'd1: return 7'b1111101;
      2'd2: return 7'b0100100;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [14*NM-1:0] disp(input int n, input bit blink);
    logic [14*NM-1:0] h;
    logic [4:0] e;
    h = '1;
    for (int k = 0; k < NM; k++) begin
      if (vo[n] + k < cnt[n]) begin
        e = hist[n][cnt[n] - 1 - vo[n] - k];
        h[14*k +: 14] = {(blink && vo[n] != 0) ? 7'h7f : face_seg(e[4:2]), turn_seg(e[1:0])};
      end
    end
    return h;
  endfunction

  function automatic bit exp_ready(input int n);
    return !undo && (n == 0 || cnt[n] < DP);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        cnt[n] = 0;
        vo[n] = 0;
        exp_hex[n] = '1;
      end
      bcnt = 0;
      mvalid = 1;
    end else if (mvalid) begin
      for (int n = 0; n < 2; n++) begin
        int maxo;
        bit rdy;
        exp_hex[n] = disp(n, ((bcnt >> (BW - 1)) & 1) != 0);
        rdy = exp_ready(n);
        maxo = (cnt[n] > NM) ? cnt[n] - NM : 0;
        if (undo) begin
          if (cnt[n] > 0) begin
            cnt[n]--;
            vo[n] = 0;
          end
        end else if (move_valid && rdy) begin
          if (cnt[n] == DP) begin
            for (int j = 0; j < DP - 1; j++) hist[n][j] = hist[n][j+1];
            hist[n][DP-1] = {face, turn};
          end else begin
            hist[n][cnt[n]] = {face, turn};
            cnt[n]++;
          end
          vo[n] = 0;
        end else if (so && !sn && vo[n] < maxo) begin
          vo[n]++;
        end else if (sn && !so && vo[n] > 0) begin
          vo[n]--;
        end
      end
      bcnt = (bcnt + 1) % (1 << BW);
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("count_a", 64'(count_a), 64'(cnt[0]));
      chk("count_b", 64'(count_b), 64'(cnt[1]));
      chk("ready_a", 64'(ready_a), 64'(exp_ready(0)));
      chk("ready_b", 64'(ready_b), 64'(exp_ready(1)));
      chk("hex_a", 64'(hex_a), 64'(exp_hex[0]));
      chk("hex_b", 64'(hex_b), 64'(exp_hex[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input int f, input int t, input bit u, input bit o, input bit w);
    move_valid = v; face = 3'(f); turn = 2'(t); undo = u; so = o; sn = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    int nb, nl;
    do_reset;
    chk("rst_hex", 64'(hex_a), 64'({14*NM{1'b1}}));
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_ready", 64'(ready_a), 64'd1);

    // three back-to-back moves
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 5, 2, 0, 0, 0);
    chk("push3_count", 64'(count_a), 64'd3);
    idle(1);
    chk("push3_slot0", 64'(hex_a[13:0]), 64'(14'b0100001_0100100));
    chk("push3_slot1", 64'(hex_a[27:14]), 64'(14'b0101111_1111101));
    chk("push3_slot2", 64'(hex_a[41:28]), 64'(14'b1000001_1111111));

    // 17 pushes then 17 undos
    do_reset;
    for (int i = 0; i < 17; i++) begin
      cyc(1, i % 6, i % 3, 0, 0, 0);
      chk("ow_ready", 64'(ready_a), 64'd1);
    end
    chk("ow_count_a", 64'(count_a), 64'd16);
    chk("ow_count_b", 64'(count_b), 64'd16);
    chk("stall_ready_b", 64'(ready_b), 64'd0);
    idle(1);
    chk("ow_slot0", 64'(hex_a[13:0]), 64'(14'b0000011_1111101));
    chk("stall_slot0", 64'(hex_b[13:0]), 64'(14'b0001110_1111111));
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("undo_count", 64'(count_a), 64'd0);
    idle(1);
    chk("undo_hex", 64'(hex_a), 64'({14*NM{1'b1}}));

    // stalled push held across an undo
    do_reset;
    for (int i = 0; i < 16; i++) cyc(1, i % 6, i % 3, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    chk("held_count_b", 64'(count_b), 64'd16);
    move_valid = 1; face = 3'd1; turn = 2'd0; undo = 1;
    #1;
    chk("undo_ready_b", 64'(ready_b), 64'd0);
    chk("undo_ready_a", 64'(ready_a), 64'd0);
    @(posedge clk); #1;
    chk("held_undo_count", 64'(count_b), 64'd15);
    undo = 0;
    #1;
    chk("held_ready_b", 64'(ready_b), 64'd1);
    @(posedge clk); #1;
    chk("held_accept_count", 64'(count_b), 64'd16);
    idle(1);
    chk("held_slot0", 64'(hex_b[13:0]), 64'(14'b0101111_1111111));

    // scroll-back and blink
    do_reset;
    for (int i = 0; i < 10; i++) cyc(1, i % 6, i % 3, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    idle(1);
    chk("scroll_mod", 64'(hex_a[6:0]), 64'(7'b0100100));
    nb = 0; nl = 0;
    for (int i = 0; i < 32; i++) begin
      idle(1);
      if (hex_a[13:7] == 7'h7f) nb++;
      if (hex_a[13:7] == 7'b1000111) nl++;
    end
    chk("blink_both_phases", 64'(nb > 0 && nl > 0 && nb + nl == 32), 64'd1);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    chk("scroll_newer_mod", 64'(hex_a[6:0]), 64'(7'b1111101));
    cyc(1, 3, 0, 0, 0, 0);
    nb = 0;
    for (int i = 0; i < 32; i++) begin
      idle(1);
      if (hex_a[13:7] != 7'b0001110) nb++;
    end
    chk("live_no_blink", 64'(nb), 64'd0);

    // undo vs push, both scrolls, invalid codes, reset mid-stream
    do_reset;
    for (int i = 0; i < 5; i++) cyc(1, i, 0, 0, 0, 0);
    move_valid = 1; face = 3'd2; undo = 1;
    #1;
    chk("undo_push_ready", 64'(ready_a), 64'd0);
    @(posedge clk); #1;
    chk("undo_push_count", 64'(count_a), 64'd4);
    for (int i = 0; i < 5; i++) cyc(1, i, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    idle(2);
    cyc(1, 7, 3, 0, 0, 0);
    idle(1);
    chk("invalid_slot0", 64'(hex_a[13:0]), 64'(14'b0111111_0111111));
    reset = 1;
    cyc(1, 2, 0, 0, 0, 0);
    reset = 0;
    chk("midrst_count", 64'(count_a), 64'd0);
    chk("midrst_hex", 64'(hex_a), 64'({14*NM{1'b1}}));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, u, o, w;
      v = ($urandom_range(0, 99) < 60);
      u = ($urandom_range(0, 99) < 12);
      o = ($urandom_range(0, 99) < 25);
      w = ($urandom_range(0, 99) < 15);
      reset = ($urandom_range(0, 199) == 0);
      cyc(v, $urandom_range(0, 7), $urandom_range(0, 3), u, o, w);
    end
    reset = 0;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_move_history.md
# seven_segment_move_history

Buffered, parametrised move-history display for the cube simulator. Accepts solver/user moves over a valid/ready interface, stores the last DEPTH moves in a circular buffer, and drives NUM_MOVES pairs of active-low seven-segment digits (face letter + turn modifier) with undo and scroll-back. Sits between the move generator and the board HEX outputs, replacing per-digit combinational move decoding.

## Interface
- NUM_MOVES, 3: moves shown simultaneously; each uses two digits (HEX0–HEX5 at default).
- DEPTH, 16: history buffer entries; power of two, DEPTH ≥ NUM_MOVES.
- OVERWRITE, 1: 1 = full buffer drops oldest entry on push; 0 = full buffer stalls pushes.
- BLINK_W, 24: blink counter width; blink phase = counter MSB.
- CLOCK_50  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- move_valid  in  1  move present on move_face/move_turn.
- move_face  in  3  0=U 1=R 2=L 3=F 4=B 5=D; 6,7 invalid.
- move_turn  in  2  0=CW 1=CCW 2=double; 3 invalid.
- move_ready  out  1  combinational; push accepted when move_valid && move_ready.
- undo  in  1  single-cycle pulse (pre-debounced): remove newest move.
- scroll_older  in  1  single-cycle pulse: view one move further back.
- scroll_newer  in  1  single-cycle pulse: view one move forward.
- count  out  $clog2(DEPTH+1)  stored moves, 0..DEPTH.
- hex_out  out  14*NUM_MOVES  slot k: [14k+13:14k+7] face digit, [14k+6:14k] modifier digit; slot 0 newest visible (rightmost).

## Operation
- Segment encoding: bit0=a … bit6=g, active low. U 1000001, R 0101111, L 1000111, F 0001110, B 0000011, D 0100001. Modifier: CW 1111111 (blank), CCW 1111101 (prime), double 0100100 ("2"). Invalid face or turn code: dash 0111111 on that digit. Empty slot: both digits 1111111.
- Buffer: DEPTH×5-bit entries, write pointer wr_ptr (mod DEPTH), count.
- move_ready = !undo && (OVERWRITE || count < DEPTH).
- Push: entry written at wr_ptr, wr_ptr+1 mod DEPTH; count+1 saturating at DEPTH (OVERWRITE=1 full: count stays DEPTH, oldest lost).
- Undo: if count>0, wr_ptr−1 mod DEPTH, count−1; if count=0, no effect. Undo beats push in the same cycle (ready low, move not consumed).
- View offset view_off, 0..max_off, max_off = count>NUM_MOVES ? count−NUM_MOVES : 0.
- scroll_older: view_off+1 if < max_off. scroll_newer: view_off−1 if > 0. Both same cycle: no change.
- Any accepted push or effective undo forces view_off=0 (snap to live), overriding scroll that cycle.
- Slot k shows entry at (wr_ptr−1−view_off−k) mod DEPTH when view_off+k < count, else empty.
- Blink: free-running BLINK_W counter. When view_off≠0 and counter MSB=1, all face digits blank (modifiers still shown). view_off=0: no blink.

## Timing
- Reset values: hex_out all 1s, count 0, wr_ptr 0, view_off 0, blink counter 0; move_ready=1 after reset unless undo high.
- Buffer/count/view_off update at edge N of the accepting cycle; count valid after edge N; hex_out registered, reflects edge-N state after edge N+1 (one-cycle display latency).
- Back-to-back pushes every cycle sustained; no bubbles.
- Reset mid-operation discards all history the same edge; push presented with reset is dropped.
- Wrap-around: wr_ptr DEPTH−1 → 0 on push, 0 → DEPTH−1 on undo; display indexing mod DEPTH.
- max_off recomputed from post-update count; view_off never exceeds it.

## Test plan
- Reset, push U/CW, R/CCW, D/double back-to-back -> count=3; two cycles later slot0 = 0100001/0100100, slot1 = 0101111/1111101, slot2 = 1000001/1111111.
- OVERWRITE=1, DEPTH=16: push 17 moves (face=i mod 6) -> count stays 16, move_ready always 1, slot0 shows move 17 (face 4 → 0000011); undo 16 times -> count=0, all hex_out 1s; 17th undo no effect.
- OVERWRITE=0: push 16 moves -> move_ready=0; 17th move_valid held -> not accepted; undo -> ready=1 next cycle, held move accepted, count=16.
- 10 moves stored, scroll_older ×10 -> view_off saturates at 7; slot0 shows move 3; face digits blink with counter MSB; scroll_newer ×2 -> view_off=5; push -> view_off=0, blinking stops.
- undo and move_valid same cycle with count=5 -> count=4, move_ready=0 that cycle; scroll_older and scroll_newer together -> view_off unchanged.
- Push face 7 turn 3 -> slot0 both digits 0111111; assert reset mid-stream -> next cycle count=0, hex_out all 1s.
